// File: rtl/pi_map_n_if.sv
// pi_map_n_if: PI bus strobes/address plus decoder enables, handshake and error capture
interface pi_map_n_if #(
    parameter int CH = 8,
    parameter int AW = 25
);
    logic [AW-1:0] pi_addr;
    logic          pi_oe;
    logic          pi_we;
    logic          err_clr;
    logic [CH-1:0] ce;
    logic [3:0]    hit_idx;
    logic          ack;
    logic          miss;
    logic          err;
    logic [AW-1:0] err_addr;
    logic [7:0]    err_cnt;
    modport master(output pi_addr, pi_oe, pi_we, err_clr,
                   input ce, hit_idx, ack, miss, err, err_addr, err_cnt);
    modport slave(input pi_addr, pi_oe, pi_we, err_clr,
                  output ce, hit_idx, ack, miss, err, err_addr, err_cnt);
endinterface

// File: rtl/pi_map_n.sv
// pi_map_n: registered base/mask PI address decoder with per-region wait states and miss capture
module pi_map_n #(
    parameter int                 CH   = 8,
    parameter int                 AW   = 25,
    parameter logic [CH*AW-1:0]   BASE = '0,
    parameter logic [CH*AW-1:0]   MASK = '0,
    parameter logic [CH*4-1:0]    WS   = '0
) (
    input logic        clk,
    input logic        rst_n,
    pi_map_n_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, MISS} state_t;
    state_t        state;
    logic          exec, exec_q, seen_low, rise, any;
    logic [3:0]    cnt, idx, ws_sel;
    logic [CH-1:0] hit;
    // Strobe merge, rise detection gated until exec has been seen low after reset
    always_comb begin
        exec = bus.pi_oe | bus.pi_we;
        rise = exec & ~exec_q & seen_low;
    end
    for (genvar i = 0; i < CH; i++) begin : g_hit
        assign hit[i] = ((bus.pi_addr ^ BASE[i*AW +: AW]) & MASK[i*AW +: AW]) == '0;
    end
    // Lowest matching region wins; its wait-state count travels with it
    always_comb begin
        idx    = '0;
        ws_sel = '0;
        any    = 1'b0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx    = 4'(i);
                ws_sel = WS[i*4 +: 4];
                any    = 1'b1;
            end
        end
    end
    // Access FSM with registered enables, handshake and sticky miss capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            exec_q       <= 1'b0;
            seen_low     <= 1'b0;
            cnt          <= '0;
            bus.ce       <= '0;
            bus.hit_idx  <= '0;
            bus.ack      <= 1'b0;
            bus.miss     <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_addr <= '0;
            bus.err_cnt  <= '0;
        end else begin
            exec_q <= exec;
            if (!exec) seen_low <= 1'b1;
            if (bus.err_clr) begin
                bus.err      <= 1'b0;
                bus.err_addr <= '0;
                bus.err_cnt  <= '0;
            end
            case (state)
                IDLE: if (rise) begin
                    if (any) begin
                        bus.ce      <= CH'(1) << idx;
                        bus.hit_idx <= idx;
                        if (ws_sel == '0) begin
                            state   <= DONE;
                            bus.ack <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= ws_sel - 4'd1;
                        end
                    end else begin
                        state        <= MISS;
                        bus.ack      <= 1'b1;
                        bus.miss     <= 1'b1;
                        bus.err      <= 1'b1;
                        bus.err_addr <= (!bus.err || bus.err_clr) ? bus.pi_addr : bus.err_addr;
                        bus.err_cnt  <= bus.err_clr ? 8'd1 : (bus.err_cnt == 8'hff ? 8'hff : bus.err_cnt + 8'd1);
                    end
                end
                WAIT: if (!exec) begin
                    state       <= IDLE;
                    bus.ce      <= '0;
                    bus.hit_idx <= '0;
                end else if (cnt == '0) begin
                    state   <= DONE;
                    bus.ack <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: if (!exec) begin
                    state       <= IDLE;
                    bus.ce      <= '0;
                    bus.hit_idx <= '0;
                    bus.ack     <= 1'b0;
                end
                MISS: if (!exec) begin
                    state    <= IDLE;
                    bus.ack  <= 1'b0;
                    bus.miss <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pi_map_n.sv
// tb_pi_map_n: directed vectors for the 3-region decoder configuration
module tb_pi_map_n;
    localparam int CH = 3;
    localparam int AW = 25;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    pi_map_n_if #(.CH(CH), .AW(AW)) bus ();
    pi_map_n #(
        .CH(CH), .AW(AW),
        .BASE({25'h1800000, 25'h0800000, 25'h0000000}),
        .MASK({25'h1F00000, 25'h1800000, 25'h1800000}),
        .WS({4'd2, 4'd1, 4'd0})
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    // Free-running clock
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.pi_addr = '0;
        bus.pi_oe   = 1'b0;
        bus.pi_we   = 1'b0;
        bus.err_clr = 1'b0;
        step();
        step();
        check("rst_ce", 32'(bus.ce), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_err_cnt", 32'(bus.err_cnt), 0);
        rst_n = 1'b1;
        step();
        step();
        bus.pi_addr = 25'h0001234;
        bus.pi_oe   = 1'b1;
        step();
        check("r0_ce", 32'(bus.ce), 3'b001);
        check("r0_idx", 32'(bus.hit_idx), 0);
        check("r0_ack", 32'(bus.ack), 1);
        check("r0_miss", 32'(bus.miss), 0);
        bus.pi_oe = 1'b0;
        step();
        check("r0_ce_clr", 32'(bus.ce), 0);
        check("r0_ack_clr", 32'(bus.ack), 0);
        bus.pi_addr = 25'h1800010;
        bus.pi_we   = 1'b1;
        step();
        check("r2_ce", 32'(bus.ce), 3'b100);
        check("r2_idx", 32'(bus.hit_idx), 2);
        check("r2_ack_e0", 32'(bus.ack), 0);
        step();
        check("r2_ack_e1", 32'(bus.ack), 0);
        step();
        check("r2_ack_e2", 32'(bus.ack), 1);
        step();
        check("r2_ack_hold", 32'(bus.ack), 1);
        check("r2_ce_hold", 32'(bus.ce), 3'b100);
        bus.pi_we = 1'b0;
        step();
        check("r2_ack_clr", 32'(bus.ack), 0);
        check("r2_ce_clr", 32'(bus.ce), 0);
        bus.pi_addr = 25'h1000000;
        bus.pi_oe   = 1'b1;
        step();
        check("m1_ack", 32'(bus.ack), 1);
        check("m1_miss", 32'(bus.miss), 1);
        check("m1_ce", 32'(bus.ce), 0);
        check("m1_idx", 32'(bus.hit_idx), 0);
        check("m1_err", 32'(bus.err), 1);
        check("m1_err_addr", 32'(bus.err_addr), 32'h1000000);
        check("m1_err_cnt", 32'(bus.err_cnt), 1);
        bus.pi_oe = 1'b0;
        step();
        check("m1_miss_clr", 32'(bus.miss), 0);
        check("m1_ack_clr", 32'(bus.ack), 0);
        bus.pi_addr = 25'h1100000;
        bus.pi_oe   = 1'b1;
        step();
        check("m2_err_addr", 32'(bus.err_addr), 32'h1000000);
        check("m2_err_cnt", 32'(bus.err_cnt), 2);
        bus.pi_oe = 1'b0;
        step();
        bus.pi_addr = 25'h0800004;
        bus.pi_oe   = 1'b1;
        step();
        check("ab_ce", 32'(bus.ce), 3'b010);
        check("ab_idx", 32'(bus.hit_idx), 1);
        check("ab_ack_e0", 32'(bus.ack), 0);
        bus.pi_oe = 1'b0;
        step();
        check("ab_ce_clr", 32'(bus.ce), 0);
        check("ab_ack_none", 32'(bus.ack), 0);
        bus.pi_oe = 1'b1;
        step();
        check("re_ce", 32'(bus.ce), 3'b010);
        check("re_ack_e0", 32'(bus.ack), 0);
        step();
        check("re_ack_e1", 32'(bus.ack), 1);
        bus.pi_oe = 1'b0;
        step();
        check("re_ack_clr", 32'(bus.ack), 0);
        bus.pi_addr = 25'h1200000;
        bus.pi_oe   = 1'b1;
        bus.err_clr = 1'b1;
        step();
        check("cm_err", 32'(bus.err), 1);
        check("cm_err_addr", 32'(bus.err_addr), 32'h1200000);
        check("cm_err_cnt", 32'(bus.err_cnt), 1);
        bus.pi_oe   = 1'b0;
        bus.err_clr = 1'b0;
        step();
        bus.err_clr = 1'b1;
        step();
        check("clr_err", 32'(bus.err), 0);
        check("clr_err_addr", 32'(bus.err_addr), 0);
        check("clr_err_cnt", 32'(bus.err_cnt), 0);
        bus.err_clr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.pi_oe = 1'b1;
            step();
            bus.pi_oe = 1'b0;
            step();
        end
        check("sat_err_cnt", 32'(bus.err_cnt), 255);
        check("sat_err_addr", 32'(bus.err_addr), 32'h1200000);
        bus.pi_addr = 25'h1800010;
        bus.pi_we   = 1'b1;
        step();
        check("rw_ce", 32'(bus.ce), 3'b100);
        #1 rst_n = 1'b0;
        #1;
        check("ar_ce", 32'(bus.ce), 0);
        check("ar_idx", 32'(bus.hit_idx), 0);
        check("ar_ack", 32'(bus.ack), 0);
        check("ar_err", 32'(bus.err), 0);
        check("ar_err_cnt", 32'(bus.err_cnt), 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        step();
        check("held_ce", 32'(bus.ce), 0);
        check("held_ack", 32'(bus.ack), 0);
        check("held_miss", 32'(bus.miss), 0);
        bus.pi_we = 1'b0;
        step();
        bus.pi_we = 1'b1;
        step();
        check("fresh_ce", 32'(bus.ce), 3'b100);
        bus.pi_we = 1'b0;
        step();
        check("fresh_ce_clr", 32'(bus.ce), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
